// File: rtl/sram_fetch_tracker.sv
// sram_fetch_tracker
//   Tracks instruction-fetch requests issued to an SRAM-style bus that
//   returns data in order. Accepted addresses wait in an address FIFO until
//   their data arrives; live responses then wait in a response FIFO for the
//   consumer. A flush marks every outstanding request as cancelled (its data
//   is dropped on arrival) and empties the response FIFO.
// Ports
//   clk, resetn                      clock, async active-low reset
//   req_valid/req_addr/req_ready     fetch-stage request handshake
//   sram_req/sram_addr/sram_addr_ok  bus address phase
//   sram_data_ok/sram_rdata          bus data phase (oldest request first)
//   flush                            cancel everything outstanding
//   rsp_valid/rsp_addr/rsp_data/rsp_ready  response handshake
//   occupancy                        in-flight + buffered count (registered)
//   err                              sticky: data returned with nothing in flight
module sram_fetch_tracker #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   req_valid,
  input  logic [AW-1:0]          req_addr,
  output logic                   req_ready,
  output logic                   sram_req,
  output logic [AW-1:0]          sram_addr,
  input  logic                   sram_addr_ok,
  input  logic                   sram_data_ok,
  input  logic [DW-1:0]          sram_rdata,
  input  logic                   flush,
  output logic                   rsp_valid,
  output logic [AW-1:0]          rsp_addr,
  output logic [DW-1:0]          rsp_data,
  input  logic                   rsp_ready,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic                   err
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // address FIFO
  logic [AW-1:0]    r_af_addr [DEPTH];
  logic [DEPTH-1:0] r_af_cancel;
  logic [PW-1:0]    r_af_wp, r_af_rp;
  logic [CW-1:0]    r_inflight_cnt;
  // response FIFO
  logic [AW-1:0]    r_rf_addr [DEPTH];
  logic [DW-1:0]    r_rf_data [DEPTH];
  logic [PW-1:0]    r_rf_wp, r_rf_rp;
  logic [CW-1:0]    r_rsp_cnt;

  logic [CW-1:0]    r_occ;
  logic             r_err;

  logic [CW-1:0]    w_occ;
  logic             w_sram_req, w_push_af, w_pop_af, w_push_rf, w_pop_rf;
  logic [CW-1:0]    w_inflight_nxt, w_rsp_nxt;

  always_comb begin
    // Issue decision uses registered counts only, so a slot freed by this
    // cycle's data_ok or response pop is reusable next cycle at the earliest.
    w_occ      = r_inflight_cnt + r_rsp_cnt;
    w_sram_req = resetn & req_valid & ~flush & (w_occ < CW'(DEPTH));
    w_push_af  = w_sram_req & sram_addr_ok;
    w_pop_af   = sram_data_ok & (r_inflight_cnt != '0);
    // Cancelled entries, and any data landing on a flush edge, are dropped.
    w_push_rf  = w_pop_af & ~r_af_cancel[r_af_rp] & ~flush;
    w_pop_rf   = (r_rsp_cnt != '0) & rsp_ready & ~flush;
    w_inflight_nxt = r_inflight_cnt + CW'(w_push_af) - CW'(w_pop_af);
    w_rsp_nxt      = flush ? '0 : (r_rsp_cnt + CW'(w_push_rf) - CW'(w_pop_rf));
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_af_cancel    <= '0;
      r_af_wp        <= '0;
      r_af_rp        <= '0;
      r_inflight_cnt <= '0;
      r_rf_wp        <= '0;
      r_rf_rp        <= '0;
      r_rsp_cnt      <= '0;
      r_occ          <= '0;
      r_err          <= 1'b0;
    end else begin
      if (w_push_af) r_af_wp <= r_af_wp + PW'(1);
      if (w_pop_af)  r_af_rp <= r_af_rp + PW'(1);
      // Marking every slot is equivalent to marking only resident ones: a
      // free slot gets its bit cleared when it is next written, and no push
      // can happen on a flush cycle.
      if (flush)          r_af_cancel          <= '1;
      else if (w_push_af) r_af_cancel[r_af_wp] <= 1'b0;
      if (flush) begin
        r_rf_rp <= r_rf_wp;
      end else begin
        if (w_push_rf) r_rf_wp <= r_rf_wp + PW'(1);
        if (w_pop_rf)  r_rf_rp <= r_rf_rp + PW'(1);
      end
      r_inflight_cnt <= w_inflight_nxt;
      r_rsp_cnt      <= w_rsp_nxt;
      r_occ          <= w_inflight_nxt + w_rsp_nxt;
      if (sram_data_ok && r_inflight_cnt == '0) r_err <= 1'b1;
    end
  end

  // storage needs no reset; validity is carried by the pointers/counters
  always_ff @(posedge clk) begin
    if (w_push_af) r_af_addr[r_af_wp] <= req_addr;
    if (w_push_rf) begin
      r_rf_addr[r_rf_wp] <= r_af_addr[r_af_rp];
      r_rf_data[r_rf_wp] <= sram_rdata;
    end
  end

  assign sram_req  = w_sram_req;
  assign sram_addr = req_addr;
  assign req_ready = w_push_af;
  assign rsp_valid = (r_rsp_cnt != '0);
  assign rsp_addr  = r_rf_addr[r_rf_rp];
  assign rsp_data  = r_rf_data[r_rf_rp];
  assign occupancy = r_occ;
  assign err       = r_err;
endmodule

// File: tb/tb_sram_fetch_tracker.sv
module tb_sram_fetch_tracker;
  localparam int DEPTH = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic resetn;
  logic req_valid, sram_addr_ok, sram_data_ok, flush, rsp_ready;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] sram_rdata;
  logic req_ready, sram_req, rsp_valid, err;
  logic [AW-1:0] sram_addr, rsp_addr;
  logic [DW-1:0] rsp_data;
  logic [$clog2(DEPTH):0] occupancy;

  int checks = 0;
  int errors = 0;

  sram_fetch_tracker #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .sram_req(sram_req), .sram_addr(sram_addr), .sram_addr_ok(sram_addr_ok),
    .sram_data_ok(sram_data_ok), .sram_rdata(sram_rdata), .flush(flush),
    .rsp_valid(rsp_valid), .rsp_addr(rsp_addr), .rsp_data(rsp_data),
    .rsp_ready(rsp_ready), .occupancy(occupancy), .err(err)
  );

  always #5 clk = ~clk;

  // reference model: outstanding requests and buffered responses as queues
  typedef struct { logic [AW-1:0] addr; bit cancel; } inf_t;
  typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; } rsp_t;
  inf_t m_inf[$];
  rsp_t m_rsp[$];
  bit   m_err;

  function automatic bit m_req();
    return req_valid && !flush && (m_inf.size() + m_rsp.size() < DEPTH);
  endfunction

  function automatic int m_occ();
    return m_inf.size() + m_rsp.size();
  endfunction

  // apply one clock edge to the model using the inputs currently driven
  task automatic model_edge();
    inf_t e;
    rsp_t r;
    bit accept;
    accept = m_req() && sram_addr_ok;
    if (rsp_ready && m_rsp.size() > 0) r = m_rsp.pop_front();
    if (sram_data_ok) begin
      if (m_inf.size() > 0) begin
        e = m_inf.pop_front();
        if (!e.cancel && !flush) begin
          r.addr = e.addr; r.data = sram_rdata;
          m_rsp.push_back(r);
        end
      end else m_err = 1;
    end
    if (flush) begin
      m_rsp.delete();
      for (int i = 0; i < m_inf.size(); i++) m_inf[i].cancel = 1;
    end
    if (accept) begin
      e.addr = req_addr; e.cancel = 0;
      m_inf.push_back(e);
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [AW-1:0] a, input bit aok,
                       input bit dok, input logic [DW-1:0] d, input bit fl, input bit rr);
    req_valid = v; req_addr = a; sram_addr_ok = aok;
    sram_data_ok = dok; sram_rdata = d; flush = fl; rsp_ready = rr;
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    m_inf.delete(); m_rsp.delete(); m_err = 0;
    drive(0, '0, 0, 0, '0, 0, 0);
    @(posedge clk); @(posedge clk); #1;
    resetn = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && m_occ() > 0; i++) begin
      drive(0, '0, 0, m_inf.size() > 0, $urandom, 0, 1);
      tick();
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    drive(1, 32'h1c00_0000, 1, 0, '0, 0, 0);
    checks++; if (sram_req !== 1'b0) begin errors++; $display("FAIL reset_sram_req got %b want 0", sram_req); end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready got %b want 0", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
    checks++; if (occupancy !== 0) begin errors++; $display("FAIL reset_occupancy got %0d want 0", occupancy); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
    do_reset();
  endtask

  task automatic test_single();
    drive(1, 32'h1c00_0000, 1, 0, '0, 0, 0);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL single_accept got %b want 1", req_ready); end
    checks++; if (sram_addr !== 32'h1c00_0000) begin errors++; $display("FAIL single_sram_addr got %h want 1c000000", sram_addr); end
    tick();
    drive(0, '0, 0, 0, '0, 0, 0);
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_early_rsp got %b want 0", rsp_valid); end
    tick();
    drive(0, '0, 0, 1, 32'h1234_5678, 0, 0);
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_rsp_same_cycle got %b want 0", rsp_valid); end
    tick();
    drive(0, '0, 0, 0, '0, 0, 0);
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL single_rsp_valid got %b want 1", rsp_valid); end
    checks++; if (rsp_addr !== 32'h1c00_0000) begin errors++; $display("FAIL single_rsp_addr got %h want 1c000000", rsp_addr); end
    checks++; if (rsp_data !== 32'h1234_5678) begin errors++; $display("FAIL single_rsp_data got %h want 12345678", rsp_data); end
    checks++; if (occupancy !== 1) begin errors++; $display("FAIL single_occ got %0d want 1", occupancy); end
    drive(0, '0, 0, 0, '0, 0, 1);
    tick();
    drive(0, '0, 0, 0, '0, 0, 0);
    checks++; if (rsp_valid !== 1'b0 || occupancy !== 0) begin errors++; $display("FAIL single_pop got valid=%b occ=%0d want 0/0", rsp_valid, occupancy); end
  endtask

  task automatic test_full();
    int accepts = 0;
    for (int i = 0; i < 6; i++) begin
      drive(1, 32'h1c00_0000 + 32'(i*4), 1, 0, '0, 0, 0);
      if (req_ready === 1'b1) accepts++;
      tick();
    end
    drive(1, 32'h1c00_0100, 1, 0, '0, 0, 0);
    checks++; if (accepts != DEPTH) begin errors++; $display("FAIL full_accepts got %0d want %0d", accepts, DEPTH); end
    checks++; if (sram_req !== 1'b0) begin errors++; $display("FAIL full_sram_req got %b want 0", sram_req); end
    checks++; if (occupancy !== DEPTH) begin errors++; $display("FAIL full_occ got %0d want %0d", occupancy, DEPTH); end
    drain();
    drive(0, '0, 0, 0, '0, 0, 0);
    checks++; if (occupancy !== 0) begin errors++; $display("FAIL full_drain_occ got %0d want 0", occupancy); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h2000_0000 + 32'(i*4), 1, 0, '0, 0, 0);
      tick();
    end
    drive(0, '0, 0, 0, '0, 1, 0);
    tick();
    drive(0, '0, 0, 0, '0, 0, 0);
    checks++; if (occupancy !== 3) begin errors++; $display("FAIL flush_occ_kept got %0d want 3", occupancy); end
    for (int i = 0; i < 3; i++) begin
      drive(0, '0, 0, 1, 32'hdead_0000 + 32'(i), 0, 1);
      tick();
      drive(0, '0, 0, 0, '0, 0, 0);
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL flush_rsp_valid got %b want 0", rsp_valid); end
      checks++; if (occupancy !== 32'(2 - i)) begin errors++; $display("FAIL flush_occ got %0d want %0d", occupancy, 2 - i); end
    end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL flush_err got %b want 0", err); end
  endtask

  task automatic test_flush_dataok();
    drive(1, 32'h3000_0000, 1, 0, '0, 0, 0); tick();   // A
    drive(1, 32'h3000_0004, 1, 0, '0, 0, 0); tick();   // B
    drive(1, 32'h3000_0008, 1, 1, 32'haaaa_aaaa, 1, 0);
    checks++; if (sram_req !== 1'b0) begin errors++; $display("FAIL fdo_req_on_flush got %b want 0", sram_req); end
    tick();
    drive(1, 32'h3000_000c, 1, 0, '0, 0, 0);           // C
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL fdo_A_dropped got %b want 0", rsp_valid); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL fdo_C_accept got %b want 1", req_ready); end
    tick();
    drive(0, '0, 0, 1, 32'hbbbb_bbbb, 0, 0); tick();   // B's data, cancelled
    drive(0, '0, 0, 0, '0, 0, 0);
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL fdo_B_dropped got %b want 0", rsp_valid); end
    drive(0, '0, 0, 1, 32'hcccc_cccc, 0, 0); tick();
    drive(0, '0, 0, 0, '0, 0, 0);
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL fdo_C_valid got %b want 1", rsp_valid); end
    checks++; if (rsp_addr !== 32'h3000_000c || rsp_data !== 32'hcccc_cccc) begin errors++; $display("FAIL fdo_C_rsp got %h/%h want 3000000c/cccccccc", rsp_addr, rsp_data); end
    drive(0, '0, 0, 0, '0, 0, 1); tick();
    drive(0, '0, 0, 0, '0, 0, 0);
    checks++; if (occupancy !== 0) begin errors++; $display("FAIL fdo_occ got %0d want 0", occupancy); end
  endtask

  // everything asserted together for many cycles; pointers wrap several times
  task automatic test_back_to_back();
    logic [AW-1:0] order[$];
    logic [AW-1:0] exp;
    int seen = 0;
    for (int i = 0; i < 24; i++) begin
      drive(1, 32'h4000_0000 + 32'(i*4), 1, m_inf.size() > 0,
            (m_inf.size() > 0) ? ~m_inf[0].addr : '0, 0, 1);
      checks++; if (req_ready !== (m_req() && sram_addr_ok)) begin errors++; $display("FAIL b2b_req_ready cyc %0d got %b want %b", i, req_ready, m_req()); end
      if (m_req()) order.push_back(req_addr);
      if (rsp_valid === 1'b1) begin
        exp = order.pop_front();
        seen++;
        checks++; if (rsp_addr !== exp || rsp_data !== ~exp) begin errors++; $display("FAIL b2b_order cyc %0d got %h/%h want %h/%h", i, rsp_addr, rsp_data, exp, ~exp); end
      end
      tick();
    end
    checks++; if (seen < 15) begin errors++; $display("FAIL b2b_throughput got %0d want >=15", seen); end
    drain();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(3, 0) != 0, {$urandom_range(255, 0), 2'b00}, $urandom_range(2, 0) != 0,
            (m_inf.size() > 0) && ($urandom_range(1, 0) == 1), $urandom,
            $urandom_range(24, 0) == 0, $urandom_range(2, 0) != 0);
      checks++; if (sram_req !== m_req()) begin errors++; $display("FAIL rnd_sram_req cyc %0d got %b want %b", i, sram_req, m_req()); end
      checks++; if (req_ready !== (m_req() && sram_addr_ok)) begin errors++; $display("FAIL rnd_req_ready cyc %0d got %b", i, req_ready); end
      checks++; if (sram_addr !== req_addr) begin errors++; $display("FAIL rnd_sram_addr cyc %0d got %h want %h", i, sram_addr, req_addr); end
      checks++; if (rsp_valid !== (m_rsp.size() > 0)) begin errors++; $display("FAIL rnd_rsp_valid cyc %0d got %b want %b", i, rsp_valid, m_rsp.size() > 0); end
      if (m_rsp.size() > 0) begin
        checks++; if (rsp_addr !== m_rsp[0].addr || rsp_data !== m_rsp[0].data) begin errors++; $display("FAIL rnd_rsp cyc %0d got %h/%h want %h/%h", i, rsp_addr, rsp_data, m_rsp[0].addr, m_rsp[0].data); end
      end
      checks++; if (occupancy !== m_occ()) begin errors++; $display("FAIL rnd_occ cyc %0d got %0d want %0d", i, occupancy, m_occ()); end
      checks++; if (err !== m_err) begin errors++; $display("FAIL rnd_err cyc %0d got %b want %b", i, err, m_err); end
      tick();
    end
    drain();
  endtask

  task automatic test_err();
    drive(0, '0, 0, 1, 32'h5555_5555, 0, 0); tick();
    for (int i = 0; i < 3; i++) begin
      drive(0, '0, 0, 0, '0, 0, 0);
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky cyc %0d got %b want 1", i, err); end
      checks++; if (occupancy !== 0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL err_ignored got occ=%0d valid=%b want 0/0", occupancy, rsp_valid); end
      tick();
    end
    do_reset();
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_cleared got %b want 0", err); end
    // reset in the middle of two outstanding requests drops them
    drive(1, 32'h6000_0000, 1, 0, '0, 0, 0); tick();
    drive(1, 32'h6000_0004, 1, 0, '0, 0, 0); tick();
    do_reset();
    checks++; if (occupancy !== 0) begin errors++; $display("FAIL midrst_occ got %0d want 0", occupancy); end
    drive(0, '0, 0, 1, 32'h7777_7777, 0, 0); tick();
    drive(0, '0, 0, 0, '0, 0, 0);
    checks++; if (err !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL midrst_err got err=%b valid=%b want 1/0", err, rsp_valid); end
    do_reset();
  endtask

  initial begin
    resetn = 1'b0;
    m_err = 0;
    drive(0, '0, 0, 0, '0, 0, 0);
    @(posedge clk); #1;
    test_reset();
    test_single();
    test_full();
    test_flush();
    test_flush_dataok();
    test_back_to_back();
    test_random();
    test_err();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sram_fetch_tracker.md
SRAM_FETCH_TRACKER -- requirements
Module: sram_fetch_tracker

Interface
REQ-001 Parameter DEPTH, 4, maximum requests in flight plus buffered responses; power of two, 2..16.
REQ-002 Parameter AW, 32, address width.
REQ-003 Parameter DW, 32, read-data width.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk and resetn.
REQ-005 clk  in  1  clock; all state changes on its rising edge.
REQ-006 resetn  in  1  asynchronous active-low reset.
REQ-007 req_valid  in  1  fetch stage has an address to issue.
REQ-008 req_addr  in  AW  address to issue.
REQ-009 req_ready  out  1  request accepted this cycle; equals sram_req & sram_addr_ok.
REQ-010 sram_req  out  1  bus request.
REQ-011 sram_addr  out  AW  bus address; equals req_addr.
REQ-012 sram_addr_ok  in  1  bus accepted the address this cycle.
REQ-013 sram_data_ok  in  1  bus returns data for the oldest in-flight request.
REQ-014 sram_rdata  in  DW  returned data.
REQ-015 flush  in  1  cancel all in-flight and buffered requests (exception or ertn redirect).
REQ-016 rsp_valid  out  1  response buffer head valid.
REQ-017 rsp_addr  out  AW  address of head response.
REQ-018 rsp_data  out  DW  data of head response.
REQ-019 rsp_ready  in  1  consumer takes head response.
REQ-020 occupancy  out  clog2(DEPTH)+1  inflight_cnt + rsp_cnt, registered.
REQ-021 err  out  1  sticky: sram_data_ok received with inflight_cnt == 0.

Function
REQ-022 Tracking: address FIFO of DEPTH entries, each holding {addr, cancel}; response FIFO of DEPTH entries, each holding {addr, data}.
REQ-023 Combinational issue: sram_req = req_valid & ~flush & (inflight_cnt + rsp_cnt < DEPTH), using registered counts only; same-cycle data_ok or rsp pop does not free a slot until the next cycle.
REQ-024 On sram_req & sram_addr_ok, push {req_addr, cancel=0} to the address FIFO and increment inflight_cnt.
REQ-025 On sram_data_ok with inflight_cnt > 0, pop the address FIFO head and decrement inflight_cnt.
REQ-026 A popped entry with cancel=0 is pushed to the response FIFO with sram_rdata; rsp_valid rises the next cycle (1-cycle latency from data_ok).
REQ-027 A popped entry with cancel=1 is discarded; rsp_valid is unaffected.
REQ-028 rsp_valid & rsp_ready pops the response FIFO head; simultaneous push and pop in one cycle keeps rsp_cnt unchanged.
REQ-029 flush, on the same edge:
  - sets cancel=1 on every address FIFO entry still resident after that edge's data_ok pop;
  - discards the data_ok data of that cycle;
  - clears the response FIFO (rsp_cnt=0);
  - issues no request, since sram_req=0.
REQ-030 Cancelled entries keep occupying slots until their data_ok arrives.
REQ-031 Simultaneous push and pop on the address FIFO in one cycle: inflight_cnt unchanged; order preserved.
REQ-032 FIFO pointers are clog2(DEPTH) bits and wrap modulo DEPTH.
REQ-033 Full condition: occupancy == DEPTH forces sram_req=0.
REQ-034 Empty condition: rsp_cnt == 0 forces rsp_valid=0.
REQ-035 sram_data_ok with inflight_cnt == 0: ignore; set err=1.

Reset
REQ-036 While resetn=0, asynchronously:
  - all pointers and counters = 0;
  - all cancel bits = 0;
  - rsp_valid=0, occupancy=0, err=0;
  - sram_req forced 0.
REQ-037 Reset asserted mid-transaction drops all state; responses arriving after deassertion with inflight_cnt=0 set err.
REQ-038 FIFO data storage needs no reset.

Verification (DEPTH=4)
REQ-039 Issue 0x1c000000 (addr_ok), data_ok with 0x12345678 two cycles later -> next cycle rsp_valid=1, rsp_addr=0x1c000000, rsp_data=0x12345678.
REQ-040 req_valid held high, addr_ok every cycle, no data_ok, rsp_ready=0 -> exactly 4 accepts, then sram_req=0 and occupancy=4.
REQ-041 Issue 3 requests, flush, then 3 data_ok -> rsp_valid stays 0, occupancy reaches 0 after the third data_ok, err=0.
REQ-042 Flush in the same cycle as data_ok of request A, with B still in flight -> A discarded, B cancelled, new request C accepted afterwards returns only C's data.
REQ-043 Same-cycle addr_ok, data_ok and rsp pop over 20 cycles, with pointer wrap -> responses in issue order, no loss or duplicate.
REQ-044 data_ok with nothing in flight -> err=1 until resetn=0.
